// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared types and constants for the serial bus arbiter
package serial_bus_pkg;
  typedef enum logic [1:0] {IDLE, OWN, SPLIT_REPLY} arb_state_t;
  typedef logic init_id_t;
  localparam init_id_t INIT_1 = 1'b0;
  localparam init_id_t INIT_2 = 1'b1;
endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: saturating inactivity counter with clear and enable, flags when it reaches TIMEOUT
module arb_timeout_ctr #(
  parameter int TIMEOUT = 16,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [W-1:0] cnt;
  assign hit = cnt == W'(TIMEOUT);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en && !hit) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-initiator bus arbiter with split-transaction sequencing for target 3
module bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_1,
  input  logic req_2,
  input  logic bus_data_in_valid,
  input  logic done,
  input  logic split_start,
  input  logic split_ready,
  output logic grant_1,
  output logic grant_2,
  output logic msel,
  output logic split,
  output logic split_pending,
  output logic busy
);
  arb_state_t state;
  init_id_t last_grant, split_owner, pick;
  logic elig_1, elig_2, owner_req, take_split, hit;
  assign elig_1 = req_1 && !(split_pending && split_owner == INIT_1);
  assign elig_2 = req_2 && !(split_pending && split_owner == INIT_2);
  assign pick = (elig_1 && elig_2) ? ~last_grant : (elig_2 ? INIT_2 : INIT_1);
  assign owner_req = msel ? req_2 : req_1;
  assign take_split = split_start && !split_pending;
  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE || bus_data_in_valid),
    .en(state != IDLE),
    .hit(hit)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      grant_1 <= 1'b0;
      grant_2 <= 1'b0;
      msel <= INIT_1;
      split <= 1'b0;
      split_pending <= 1'b0;
      busy <= 1'b0;
      last_grant <= INIT_2;
      split_owner <= INIT_1;
    end else
      case (state)
        IDLE:
          if (split_pending && split_ready) begin
            state <= SPLIT_REPLY;
            msel <= split_owner;
            grant_1 <= split_owner == INIT_1;
            grant_2 <= split_owner == INIT_2;
            split <= 1'b1;
            busy <= 1'b1;
          end else if (elig_1 || elig_2) begin
            state <= OWN;
            msel <= pick;
            last_grant <= pick;
            grant_1 <= pick == INIT_1;
            grant_2 <= pick == INIT_2;
            busy <= 1'b1;
          end
        OWN:
          if (take_split || done || !owner_req || hit) begin
            state <= IDLE;
            grant_1 <= 1'b0;
            grant_2 <= 1'b0;
            busy <= 1'b0;
            if (take_split) begin
              split_pending <= 1'b1;
              split_owner <= msel;
            end
          end
        SPLIT_REPLY:
          if (done || hit) begin
            state <= IDLE;
            grant_1 <= 1'b0;
            grant_2 <= 1'b0;
            split <= 1'b0;
            split_pending <= 1'b0;
            busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter, outputs packed as {grant_1,grant_2,msel,split,split_pending,busy}
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_1 = 1'b0;
  logic req_2 = 1'b0;
  logic bus_data_in_valid = 1'b0;
  logic done = 1'b0;
  logic split_start = 1'b0;
  logic split_ready = 1'b0;
  logic grant_1, grant_2, msel, split, split_pending, busy;
  logic [5:0] outs;
  logic [5:0] sb[$];
  logic [5:0] exp_v;
  int vectors = 0;
  int miscompares = 0;
  typedef struct packed {
    logic rn, r1, r2, v, d, ss, sr;
    logic [5:0] e;
  } row_t;
  assign outs = {grant_1, grant_2, msel, split, split_pending, busy};
  always #5 clk = ~clk;
  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_1(req_1),
    .req_2(req_2),
    .bus_data_in_valid(bus_data_in_valid),
    .done(done),
    .split_start(split_start),
    .split_ready(split_ready),
    .grant_1(grant_1),
    .grant_2(grant_2),
    .msel(msel),
    .split(split),
    .split_pending(split_pending),
    .busy(busy)
  );
  function automatic row_t rw(input logic rn, r1, r2, v, d, ss, sr, input logic [5:0] e);
    rw = '{rn: rn, r1: r1, r2: r2, v: v, d: d, ss: ss, sr: sr, e: e};
  endfunction
  task automatic drive(input row_t r);
    rst_n = r.rn;
    req_1 = r.r1;
    req_2 = r.r2;
    bus_data_in_valid = r.v;
    done = r.d;
    split_start = r.ss;
    split_ready = r.sr;
  endtask
  task automatic test_reset();
    row_t t[$];
    t = '{rw(0,1,1,1,0,0,0,6'b000000), rw(1,1,0,1,0,0,0,6'b100001), rw(1,1,0,1,0,0,0,6'b100001),
          rw(1,1,0,1,1,0,0,6'b000000), rw(1,0,0,1,0,0,0,6'b000000), rw(1,0,0,1,0,1,0,6'b000000),
          rw(1,0,0,1,0,0,1,6'b000000)};
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i].e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (outs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_single step %0d: got %b want %b", i, outs, exp_v);
      end
    end
  endtask
  task automatic test_back_to_back();
    row_t r;
    drive(rw(0,0,0,1,0,0,0,6'b000000));
    sb.push_back(6'b000000);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    vectors++;
    if (outs !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_reset: got %b want %b", outs, exp_v);
    end
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 24; c++) begin
        r = rw(1, 1, 1, 1, c == 23, 0, 0, 6'b0);
        r.e = (c == 23) ? ((k % 2) ? 6'b001000 : 6'b000000) : ((k % 2) ? 6'b011001 : 6'b100001);
        drive(r);
        sb.push_back(r.e);
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        vectors++;
        if (outs !== exp_v) begin
          miscompares++;
          $display("FAIL b2b round %0d cycle %0d: got %b want %b", k, c, outs, exp_v);
        end
      end
  endtask
  task automatic test_split();
    row_t t[$];
    t = '{rw(0,0,0,1,0,0,0,6'b000000), rw(1,1,0,1,0,0,0,6'b100001), rw(1,1,0,1,0,1,0,6'b000010),
          rw(1,1,1,1,0,0,0,6'b011011), rw(1,1,1,1,0,0,1,6'b011011), rw(1,1,1,1,0,0,1,6'b011011),
          rw(1,1,1,1,1,0,1,6'b001010), rw(1,1,1,1,0,0,1,6'b100111), rw(1,1,1,1,0,0,1,6'b100111),
          rw(1,1,1,1,1,0,1,6'b000000), rw(1,0,0,1,0,0,0,6'b000000)};
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i].e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (outs !== exp_v) begin
        miscompares++;
        $display("FAIL split step %0d: got %b want %b", i, outs, exp_v);
      end
    end
  endtask
  task automatic test_timeout();
    row_t t[$];
    t = '{rw(0,0,0,0,0,0,0,6'b000000), rw(1,0,1,0,0,0,0,6'b011001), rw(1,0,1,0,0,0,0,6'b011001),
          rw(1,0,1,0,0,0,0,6'b011001), rw(1,0,1,0,0,0,0,6'b011001), rw(1,0,1,0,0,0,0,6'b011001),
          rw(1,0,1,0,0,0,0,6'b001000), rw(1,0,1,0,0,0,0,6'b011001)};
    for (int c = 0; c < 12; c++) t.push_back(rw(1, 0, 1, (c % 6) >= 3, 0, 0, 0, 6'b011001));
    t.push_back(rw(1,0,0,0,0,0,0,6'b001000));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i].e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (outs !== exp_v) begin
        miscompares++;
        $display("FAIL timeout step %0d: got %b want %b", i, outs, exp_v);
      end
    end
  endtask
  task automatic test_split_done();
    row_t t[$];
    t = '{rw(0,0,0,1,0,0,0,6'b000000), rw(1,1,0,1,0,0,0,6'b100001), rw(1,1,0,1,1,1,0,6'b000010),
          rw(1,0,1,1,0,0,0,6'b011011), rw(1,0,1,1,0,1,0,6'b011011), rw(1,0,1,1,1,0,0,6'b001010),
          rw(1,0,0,1,0,0,1,6'b100111), rw(1,0,0,1,1,0,1,6'b000000)};
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i].e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (outs !== exp_v) begin
        miscompares++;
        $display("FAIL split_done step %0d: got %b want %b", i, outs, exp_v);
      end
    end
  endtask
  task automatic test_reset_mid_split();
    row_t t[$];
    t = '{rw(0,0,0,1,0,0,0,6'b000000), rw(1,1,0,1,0,0,0,6'b100001), rw(1,1,0,1,0,1,0,6'b000010),
          rw(1,0,0,1,0,0,1,6'b100111), rw(0,0,0,1,0,0,1,6'b000000), rw(1,0,0,1,0,0,1,6'b000000),
          rw(1,0,0,1,0,0,1,6'b000000)};
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i].e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (outs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_split step %0d: got %b want %b", i, outs, exp_v);
      end
    end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_split();
    test_timeout();
    test_split_done();
    test_reset_mid_split();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
